// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data-memory request port; byte-lane writes, aligned/extended loads.
// Latency: accept on edge N, rsp_valid after edge N+1+WAIT_CYCLES (after edge N itself when WAIT_CYCLES = 0).
// Backpressure: one request in flight, response held until rsp_ready; `DMEM_RESP_PIPELINE_EN accepts on the handshake edge.

`ifndef ENCDEC_BYTE
`define ENCDEC_BYTE 2'b00
`endif
`ifndef ENCDEC_HALF
`define ENCDEC_HALF 2'b01
`endif
`ifndef ENCDEC_WORD
`define ENCDEC_WORD 2'b10
`endif

module dmem_responder #(
   parameter int ADDR_W      = 11,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [1:0]        req_width,
   input  logic              req_zero_ext,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Everything about a request that is needed on the commit edge.
   // A request with write set is a store even when read is also set.
   typedef struct packed {
      logic              write;
      logic [1:0]        width;
      logic              zero_ext;
      logic [ADDR_W-1:0] word;
      logic [1:0]        off;
      logic [31:0]       wdata;
   } op_t;

   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept, enter_resp;
   op_t         op_in, op_q, op_cur;
   logic        is_byte, is_half, mis;
   logic [3:0]  be;
   logic [31:0] wd, rd_word, ld_data;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   logic [31:0] mem [2**ADDR_W];

   // Next-state logic: accept in IDLE, count wait states, hold response until handshake.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      req_ready  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && (req_read || req_write)) begin
               accept  = 1'b1;
               cnt_nxt = 4'd0;
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         // WAIT spans cnt = 0..WC, so the response lands WAIT_CYCLES+1 edges after accept.
         WAIT: begin
            if (cnt == WC) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
               cnt_nxt    = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
`ifdef DMEM_RESP_PIPELINE_EN
               req_ready = 1'b1;
               if (req_valid && (req_read || req_write)) begin
                  accept  = 1'b1;
                  cnt_nxt = 4'd0;
                  if (WAIT_CYCLES == 0) begin
                     state_nxt  = RESP;
                     enter_resp = 1'b1;
                  end else begin
                     state_nxt = WAIT;
                  end
               end
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operation decode: with zero wait states the commit edge is the accept edge, so use the live request.
   always_comb begin
      op_in.write    = req_write;
      op_in.width    = req_width;
      op_in.zero_ext = req_zero_ext;
      op_in.word     = req_addr[ADDR_W+1:2];
      op_in.off      = req_addr[1:0];
      op_in.wdata    = req_wdata;
      op_cur         = accept ? op_in : op_q;

      is_byte = (op_cur.width == `ENCDEC_BYTE);
      is_half = (op_cur.width == `ENCDEC_HALF);
      mis     = (is_half && op_cur.off == 2'b11) ||
                (!is_byte && !is_half && op_cur.off != 2'b00);

      rd_word = mem[op_cur.word];
      case (op_cur.off)
         2'd0:    ld_b = rd_word[7:0];
         2'd1:    ld_b = rd_word[15:8];
         2'd2:    ld_b = rd_word[23:16];
         default: ld_b = rd_word[31:24];
      endcase
      case (op_cur.off)
         2'd0:    ld_h = rd_word[15:0];
         2'd1:    ld_h = rd_word[23:8];
         2'd2:    ld_h = rd_word[31:16];
         default: ld_h = 16'd0;
      endcase

      if (is_byte) begin
         ld_data = op_cur.zero_ext ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
         be      = 4'b0001 << op_cur.off;
         wd      = {24'd0, op_cur.wdata[7:0]} << {op_cur.off, 3'b000};
      end else if (is_half) begin
         ld_data = op_cur.zero_ext ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
         be      = 4'b0011 << op_cur.off;
         wd      = {16'd0, op_cur.wdata[15:0]} << {op_cur.off, 3'b000};
      end else begin
         ld_data = rd_word;
         be      = 4'b1111;
         wd      = op_cur.wdata;
      end
   end

   // State, counter and latched request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) op_q <= op_in;
      end
   end

   // Response register: loaded on entry to RESP, frozen until the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_valid <= 1'b1;
         rsp_err   <= mis;
         rsp_rdata <= (mis || op_cur.write) ? 32'd0 : ld_data;
      end else if (state == RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end
   end

   // Store commit: one edge, only the addressed lanes, never for misaligned requests.
   always_ff @(posedge clk) begin
      if (rst_n && enter_resp && op_cur.write && !mis) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[op_cur.word][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

endmodule
